// File: rtl/load_store_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : load_store_unit_pkg
//  Purpose : Shared FSM state encoding, RV32I funct3 width codes and small
//            request-classification helpers for the load/store unit.
//  Ports   : none (package)
//  Config  : LSU_MISALIGN_TRAP_EN (used by load_store_unit, not here)
//  Revision: 1.0  initial release
// ============================================================================
package load_store_unit_pkg;

  typedef enum logic [1:0] {
    LSU_IDLE   = 2'd0,
    LSU_ACCESS = 2'd1,
    LSU_WRITE  = 2'd2,
    LSU_RESP   = 2'd3
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Stores only have signed-less B/H/W encodings; loads also accept BU/HU.
  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    logic ok;
    ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    if (!we) begin
      ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
    end
    return ok;
  endfunction

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    return (((f3 == F3_H) || (f3 == F3_HU)) && off[0]) ||
           ((f3 == F3_W) && (off != 2'b00));
  endfunction

endpackage
`default_nettype wire

// File: rtl/load_store_unit_align.sv
`default_nettype none
// ============================================================================
//  Module  : lsu_align
//  Purpose : Combinational lane logic. Extracts and sign/zero-extends a load
//            from a cache word, and merges a byte/half store into the word.
//  Ports   : word       in  32  word read from the cache
//            offset     in  2   byte address bits [1:0] (little-endian lane)
//            funct3     in  3   RV32I width/sign code
//            wdata      in  32  store data (low byte/half for SB/SH)
//            load_data  out 32  extended load result (0 for illegal codes)
//            store_word out 32  word to write back
//  Revision: 1.0  initial release
// ============================================================================
module lsu_align
  import load_store_unit_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[7:0];
    case (offset)
      2'd0: byte_sel = word[7:0];
      2'd1: byte_sel = word[15:8];
      2'd2: byte_sel = word[23:16];
      2'd3: byte_sel = word[31:24];
      default: byte_sel = word[7:0];
    endcase
    // Halfword lane ignores offset[0]; misaligned halves are trapped upstream
    // when the trap is enabled.
    half_sel = offset[1] ? word[31:16] : word[15:0];
  end

  always_comb begin
    load_data = 32'h0;
    case (funct3)
      F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_data = {24'h0, byte_sel};
      F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_data = {16'h0, half_sel};
      F3_W:    load_data = word;
      default: load_data = 32'h0;
    endcase
  end

  always_comb begin
    store_word = word;
    case (funct3)
      F3_B: begin
        case (offset)
          2'd0: store_word[7:0]   = wdata[7:0];
          2'd1: store_word[15:8]  = wdata[7:0];
          2'd2: store_word[23:16] = wdata[7:0];
          2'd3: store_word[31:24] = wdata[7:0];
          default: store_word = word;
        endcase
      end
      F3_H: begin
        if (offset[1]) store_word[31:16] = wdata[15:0];
        else           store_word[15:0]  = wdata[15:0];
      end
      F3_W:    store_word = wdata;
      default: store_word = word;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module  : load_store_unit
//  Purpose : Memory-stage front end for a word-only data cache. Converts byte
//            addresses to word indices, extends load data and performs
//            read-modify-write for SB/SH.
//  Ports   : clk, rst             clock / synchronous active-high reset
//            req_valid/ready      request handshake
//            req_we, req_funct3   store flag, RV32I width/sign code
//            req_addr, req_wdata  byte address, store data
//            resp_valid           one-cycle completion pulse
//            resp_rdata           extended load data (0 for stores/drops)
//            resp_misalign        misaligned request dropped (macro only)
//            cache_address        word index to cache
//            cache_i_val          write word to cache
//            cache_op_type        0 read, 1 write
//            cache_o_val          read word (combinational in address)
//  Config  : LSU_MISALIGN_TRAP_EN - trap misaligned H/W requests and expose
//            resp_misalign; otherwise low address bits are ignored.
//  Revision: 1.0  initial release
// ============================================================================
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter logic [31:0] CACHE_SIZE = 32'd1023,
  parameter logic [31:0] BASE_ADDR  = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
`ifdef LSU_MISALIGN_TRAP_EN
  output logic        resp_misalign,
`endif
  output logic [31:0] cache_address,
  output logic [31:0] cache_i_val,
  output logic        cache_op_type,
  input  logic [31:0] cache_o_val
);

  lsu_state_e  state;
  logic        lat_we;
  logic [2:0]  lat_funct3;
  logic [1:0]  lat_off;
  logic [31:0] lat_wdata;
  logic        lat_bad;

  logic [31:0] rel_addr;
  logic [31:0] word_index;
  logic        req_bad;
  logic [31:0] load_data;
  logic [31:0] store_word;

  assign req_ready  = (state == LSU_IDLE);
  assign rel_addr   = req_addr - BASE_ADDR;
  assign word_index = {2'b00, rel_addr[31:2]};
  // Bad requests still walk through ACCESS but never write and return 0.
  assign req_bad    = (req_addr < BASE_ADDR) || (word_index > CACHE_SIZE) ||
                      !f3_legal(req_we, req_funct3);

  // Reset gates the write strobe in the same cycle so a write in flight
  // when reset arrives never reaches the cache.
  assign cache_op_type = (state == LSU_WRITE) & ~rst;

  lsu_align u_align (
    .word       (cache_o_val),
    .offset     (lat_off),
    .funct3     (lat_funct3),
    .wdata      (lat_wdata),
    .load_data  (load_data),
    .store_word (store_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= LSU_IDLE;
      lat_we        <= 1'b0;
      lat_funct3    <= 3'b000;
      lat_off       <= 2'b00;
      lat_wdata     <= 32'h0;
      lat_bad       <= 1'b0;
      resp_valid    <= 1'b0;
      resp_rdata    <= 32'h0;
      cache_address <= 32'h0;
      cache_i_val   <= 32'h0;
`ifdef LSU_MISALIGN_TRAP_EN
      resp_misalign <= 1'b0;
`endif
    end else begin
      case (state)
        LSU_IDLE: begin
          if (req_valid) begin
            lat_we        <= req_we;
            lat_funct3    <= req_funct3;
            lat_off       <= req_addr[1:0];
            lat_wdata     <= req_wdata;
            lat_bad       <= req_bad;
            cache_address <= word_index;
`ifdef LSU_MISALIGN_TRAP_EN
            if (is_misaligned(req_funct3, req_addr[1:0])) begin
              state         <= LSU_RESP;
              resp_valid    <= 1'b1;
              resp_rdata    <= 32'h0;
              resp_misalign <= 1'b1;
            end else begin
              state <= LSU_ACCESS;
            end
`else
            state <= LSU_ACCESS;
`endif
          end
        end

        LSU_ACCESS: begin
          if (lat_bad) begin
            state      <= LSU_RESP;
            resp_valid <= 1'b1;
            resp_rdata <= 32'h0;
          end else if (!lat_we) begin
            state      <= LSU_RESP;
            resp_valid <= 1'b1;
            resp_rdata <= load_data;
          end else begin
            // store_word already holds wdata for SW, or the merged lane for SB/SH.
            state       <= LSU_WRITE;
            cache_i_val <= store_word;
            resp_rdata  <= 32'h0;
          end
        end

        LSU_WRITE: begin
          state      <= LSU_RESP;
          resp_valid <= 1'b1;
        end

        LSU_RESP: begin
          state      <= LSU_IDLE;
          resp_valid <= 1'b0;
          resp_rdata <= 32'h0;
`ifdef LSU_MISALIGN_TRAP_EN
          resp_misalign <= 1'b0;
`endif
        end

        default: state <= LSU_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module  : tb_load_store_unit
//  Purpose : Self-checking bench for load_store_unit with a word memory
//            standing in for the cache and a queue-based scoreboard.
//  Config  : LSU_MISALIGN_TRAP_EN - selects trap or ignore expectations.
//  Revision: 1.0  initial release
// ============================================================================
module tb_load_store_unit;

  localparam int          CS         = 15;
  localparam logic [31:0] CACHE_SIZE = 32'd15;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_init = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        resp_misalign;
`endif
  logic [31:0] cache_address;
  logic [31:0] cache_i_val;
  logic        cache_op_type;
  logic [31:0] cache_o_val;

  always #5 clk = ~clk;

  load_store_unit #(.CACHE_SIZE(CACHE_SIZE), .BASE_ADDR(32'h0)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_we        (req_we),
    .req_funct3    (req_funct3),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .resp_valid    (resp_valid),
    .resp_rdata    (resp_rdata),
`ifdef LSU_MISALIGN_TRAP_EN
    .resp_misalign (resp_misalign),
`endif
    .cache_address (cache_address),
    .cache_i_val   (cache_i_val),
    .cache_op_type (cache_op_type),
    .cache_o_val   (cache_o_val)
  );

  function automatic logic [31:0] init_word(input int i);
    if (i == 2) return 32'hDEADBEEF;
    return 32'h1357_9BDF ^ (32'(i) * 32'h0101_0101);
  endfunction

  // Cache stand-in: combinational read, write on the clock edge.
  logic [31:0] mem [0:CS];
  assign cache_o_val = (cache_address <= CACHE_SIZE) ? mem[cache_address[3:0]] : 32'hA5A5_A5A5;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i <= CS; i++) mem[i] <= init_word(i);
    end else if (cache_op_type && cache_address <= CACHE_SIZE) begin
      mem[cache_address[3:0]] <= cache_i_val;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        mis;
    int          due;
    int          writes;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] ref_mem [0:CS];
  int          checks = 0;
  int          errors = 0;
  int          wcount = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: plain shift/mask arithmetic over a whole word.
  function automatic logic [31:0] model_load(input logic [31:0] w, input int off, input logic [2:0] f3);
    logic [31:0] b, h;
    b = (w >> (8 * off)) & 32'hFF;
    h = (w >> (16 * (off / 2))) & 32'hFFFF;
    case (f3)
      3'b000:  return (b >= 32'd128)   ? b - 32'd256   : b;
      3'b001:  return (h >= 32'd32768) ? h - 32'd65536 : h;
      3'b010:  return w;
      3'b100:  return b;
      3'b101:  return h;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] model_store(input logic [31:0] w, input int off,
                                               input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] mask;
    int          sh;
    case (f3)
      3'b000: begin sh = 8 * off;        mask = 32'hFF   << sh; return (w & ~mask) | ((wd & 32'hFF) << sh); end
      3'b001: begin sh = 16 * (off / 2); mask = 32'hFFFF << sh; return (w & ~mask) | ((wd & 32'hFFFF) << sh); end
      default: return wd;
    endcase
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL ready_timeout: got req_ready=0 expected 1 within 20 cycles");
    end
  endtask

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
    exp_t e;
    int   idx, off, lat;
    logic legal, bad, mis;
    wait_ready();
    idx   = int'(addr >> 2);
    off   = int'(addr & 32'h3);
    legal = we ? (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010)
               : (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010 || f3 == 3'b100 || f3 == 3'b101);
    bad   = !legal || (idx > CS);
`ifdef LSU_MISALIGN_TRAP_EN
    mis = ((f3 == 3'b001 || f3 == 3'b101) && (off % 2 == 1)) || (f3 == 3'b010 && off != 0);
`else
    mis = 1'b0;
`endif
    e.rdata = 32'h0; e.mis = mis; e.writes = 0;
    if (mis)          lat = 1;
    else if (bad)     lat = 2;
    else if (!we) begin
      lat = 2;
      e.rdata = model_load(ref_mem[idx], off, f3);
    end else begin
      lat = 3;
      e.writes = 1;
      ref_mem[idx] = model_store(ref_mem[idx], off, f3, wd);
    end
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    e.due = cyc + lat - 1;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_queue_empty", 32'(exp_q.size()), 32'h0);
  endtask

  // Monitor: counts write strobes and scores every response pulse.
  always @(negedge clk) begin
    exp_t e;
    if (cache_op_type) wcount++;
    if (!rst && resp_valid) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_resp: got resp_valid=1 expected 0 (rdata %h)", resp_rdata);
      end else begin
        e = exp_q.pop_front();
        chk("resp_rdata", resp_rdata, e.rdata);
`ifdef LSU_MISALIGN_TRAP_EN
        chk("resp_misalign", {31'h0, resp_misalign}, {31'h0, e.mis});
`endif
        chk("resp_cycle", 32'(cyc), 32'(e.due));
        chk("write_pulses", 32'(wcount), 32'(e.writes));
      end
      wcount = 0;
    end
  end

  initial begin
    logic [2:0]  f3;
    logic        we;
    logic [31:0] addr;
    for (int i = 0; i <= CS; i++) ref_mem[i] = init_word(i);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    mem_init = 1'b0;

    chk("reset_req_ready",     {31'h0, req_ready},     32'h1);
    chk("reset_resp_valid",    {31'h0, resp_valid},    32'h0);
    chk("reset_resp_rdata",    resp_rdata,             32'h0);
    chk("reset_cache_address", cache_address,          32'h0);
    chk("reset_cache_i_val",   cache_i_val,            32'h0);
    chk("reset_cache_op_type", {31'h0, cache_op_type}, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("reset_resp_misalign", {31'h0, resp_misalign}, 32'h0);
`endif

    issue(1'b0, 3'b010, 32'h8, 32'h0);      // LW  -> DEADBEEF
    issue(1'b0, 3'b000, 32'h9, 32'h0);      // LB  -> FFFFFFBE
    issue(1'b0, 3'b100, 32'h9, 32'h0);      // LBU -> 000000BE
    issue(1'b0, 3'b101, 32'hA, 32'h0);      // LHU -> 0000DEAD
    issue(1'b1, 3'b000, 32'h9, 32'h11);     // SB
    drain();
    chk("sb_merge_word2", mem[2], 32'hDEAD11EF);
    issue(1'b1, 3'b010, 32'((CS + 1) * 4), 32'hCAFE_F00D);  // out of range SW
    issue(1'b0, 3'b010, 32'h6, 32'h0);      // trap or word[1]
    issue(1'b0, 3'b011, 32'h4, 32'h0);      // illegal funct3
    issue(1'b1, 3'b110, 32'h4, 32'h55);     // illegal store funct3
    drain();

    // Reset landing in the WRITE cycle of an SH must drop the write and response.
    wait_ready();
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b001; req_addr = 32'h12; req_wdata = 32'hBEEF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("sh_write_cycle_op", {31'h0, cache_op_type}, 32'h1);
    rst = 1'b1;
    #1;
    chk("rst_gates_op_type", {31'h0, cache_op_type}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_idle_ready", {31'h0, req_ready}, 32'h1);
    repeat (4) @(posedge clk);
    #1;
    chk("rst_word4_unchanged", mem[4], ref_mem[4]);

    for (int t = 0; t < 80; t++) begin
      we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) begin
        case ($urandom_range(0, 2))
          0: f3 = 3'b011;
          1: f3 = 3'b110;
          default: f3 = 3'b111;
        endcase
      end else if (we) begin
        f3 = 3'($urandom_range(0, 2));
      end else begin
        case ($urandom_range(0, 4))
          0: f3 = 3'b000;
          1: f3 = 3'b001;
          2: f3 = 3'b010;
          3: f3 = 3'b100;
          default: f3 = 3'b101;
        endcase
      end
      addr = 32'($urandom_range(0, (CS + 3) * 4 - 1));
      issue(we, f3, addr, $urandom);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
    end
    drain();

    for (int i = 0; i <= CS; i++) chk($sformatf("final_mem_%0d", i), mem[i], ref_mem[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1);
  end

endmodule
`default_nettype wire
